// File: rtl/ahb_ram_ctrl.sv
// AHB-Lite slave that bridges bus transfers onto a single-port synchronous RAM.
// Define AHB_RAM_ALIGN_CHECK_EN to make misaligned HALFWORD/WORD transfers return ERROR.

package ahb_lite_defs;
  localparam int unsigned DATAWIDTH = 32;
  localparam int unsigned ADDRWIDTH = 32;

  typedef logic [2:0] hsize_t;

  localparam hsize_t HSIZE_BYTE = 3'd0;
  localparam hsize_t HSIZE_HALF = 3'd1;
  localparam hsize_t HSIZE_WORD = 3'd2;
endpackage

module ahb_ram_ctrl
  import ahb_lite_defs::*;
#(
  parameter int unsigned MEMDEPTH   = 256,
  parameter int unsigned ADDR_LIMIT = MEMDEPTH * 4
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSEL,
  input  logic [ADDRWIDTH-1:0] HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  hsize_t               HSIZE,
  input  logic                 HREADY,
  input  logic [DATAWIDTH-1:0] HWDATA,
  output logic [DATAWIDTH-1:0] HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  output logic [ADDRWIDTH-1:0] ram_addr,
  output logic [DATAWIDTH-1:0] ram_data,
  output logic                 ram_we,
  output hsize_t               ram_size,
  input  logic [DATAWIDTH-1:0] ram_q
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_WAIT,
    RD_DONE,
    ERR1,
    ERR2
  } state_t;

  state_t               state;
  state_t               state_d;
  logic                 load_addr;
  logic                 req;
  logic                 addr_oob;
  logic                 size_bad;
  logic                 misalign;
  logic                 illegal;
  logic                 hreadyout_d;
  logic                 hresp_d;
  logic                 ram_we_d;
  logic [DATAWIDTH-1:0] data_hold;
  logic                 unused_htrans;

  // Only NONSEQ/SEQ matter; HTRANS[0] separates IDLE from BUSY, which behave alike here.
  assign unused_htrans = HTRANS[0];

  assign req      = HSEL & HREADY & HTRANS[1];
  assign addr_oob = (HADDR >= ADDRWIDTH'(ADDR_LIMIT));
  assign size_bad = (HSIZE > HSIZE_WORD);

`ifdef AHB_RAM_ALIGN_CHECK_EN
  assign misalign = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                    ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign illegal = addr_oob | size_bad | misalign;

  // Next state; the pipelined address phase is only sampled while HREADYOUT is high.
  always_comb begin
    state_d   = state;
    load_addr = 1'b0;
    case (state)
      RD_WAIT: state_d = RD_DONE;
      ERR1:    state_d = ERR2;
      default: begin
        state_d = IDLE;
        if (req) begin
          if (illegal) begin
            state_d = ERR1;
          end else begin
            load_addr = 1'b1;
            state_d   = HWRITE ? WRITE : RD_WAIT;
          end
        end
      end
    endcase
  end

  // Registered bus/RAM controls are decoded from the state being entered.
  always_comb begin
    hreadyout_d = 1'b1;
    hresp_d     = 1'b0;
    ram_we_d    = 1'b0;
    case (state_d)
      WRITE:   ram_we_d    = 1'b1;
      RD_WAIT: hreadyout_d = 1'b0;
      ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = 1'b1;
      end
      ERR2:    hresp_d     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_size  <= HSIZE_BYTE;
      data_hold <= '0;
    end else begin
      state     <= state_d;
      HREADYOUT <= hreadyout_d;
      HRESP     <= hresp_d;
      ram_we    <= ram_we_d;
      if (load_addr) begin
        ram_addr <= HADDR;
        ram_size <= HSIZE;
      end
      if (state == WRITE) begin
        data_hold <= HWDATA;
      end
    end
  end

  // Write data only exists in the data phase, so it is passed straight through and held afterwards.
  assign ram_data = (state == WRITE)   ? HWDATA : data_hold;
  assign HRDATA   = (state == RD_DONE) ? ram_q  : '0;

endmodule

// File: doc/ahb_ram_ctrl.md
AHB_RAM_CTRL -- requirements
Module: ahb_ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default MEMDEPTH*4: byte-address bound; any address >= ADDR_LIMIT is out of range.
REQ-002 SHALL use one clock and an asynchronous, active-low reset.
REQ-003 SHALL take widths DATAWIDTH, ADDRWIDTH and type hsize_t from package ahb_lite_defs.
REQ-004 HCLK  input  1  clock; every register updates on its rising edge.
REQ-005 HRESETn  input  1  asynchronous active-low reset.
REQ-006 HSEL  input  1  slave select.
REQ-007 HADDR  input  ADDRWIDTH  byte address, valid in the address phase.
REQ-008 HTRANS  input  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-009 HWRITE  input  1  1 = write, 0 = read.
REQ-010 HSIZE  input  hsize_t  transfer size: BYTE, HALFWORD or WORD.
REQ-011 HREADY  input  1  bus ready; the address phase is valid only when HREADY=1.
REQ-012 HWDATA  input  DATAWIDTH  write data, valid in the data phase.
REQ-013 HRDATA  output  DATAWIDTH  read data.
REQ-014 HREADYOUT  output  1  slave ready; 0 inserts a wait state.
REQ-015 HRESP  output  1  0 = OKAY, 1 = ERROR.
REQ-016 ram_addr  output  ADDRWIDTH  RAM port address.
REQ-017 ram_data  output  DATAWIDTH  RAM port write data.
REQ-018 ram_we  output  1  RAM port write enable.
REQ-019 ram_size  output  hsize_t  RAM port size select.
REQ-020 ram_q  input  DATAWIDTH  RAM port read data, byte-lane positioned; a read on the port updates ram_q one edge after the read address is presented.

Function
REQ-021 SHALL accept a transfer only on an edge where HSEL=1, HREADY=1 and HTRANS[1]=1, and SHALL then register HADDR, HSIZE and HWRITE.
REQ-022 IDLE/BUSY transfers, or HSEL=0, SHALL produce no RAM access and an OKAY zero-wait response.
REQ-023 FSM states SHALL be IDLE, WRITE, RD_WAIT, RD_DONE, ERR1, ERR2.
REQ-024 Accepted transfer, transition by type: legal write -> WRITE; legal read -> RD_WAIT; illegal transfer -> ERR1.
REQ-025 A transfer is illegal if its address is >= ADDR_LIMIT or HSIZE is outside {BYTE, HALFWORD, WORD}; alignment errors are added per REQ-036.
REQ-026 In WRITE: ram_we=1, ram_addr=registered address, ram_data=HWDATA, ram_size=registered size, HREADYOUT=1, HRESP=0 (zero wait).
REQ-027 In RD_WAIT: ram_we=0, ram_addr=registered address, ram_size=registered size, HREADYOUT=0; next state is RD_DONE.
REQ-028 In RD_DONE: HRDATA=ram_q unmodified, HREADYOUT=1, HRESP=0 (one wait state per read).
REQ-029 In ERR1: HREADYOUT=0, HRESP=1, no RAM access; next state is ERR2.
REQ-030 In ERR2: HREADYOUT=1, HRESP=1, no RAM access.
REQ-031 From WRITE, RD_DONE or ERR2, SHALL evaluate the pipelined next address phase on that same edge per REQ-024; with no new transfer, SHALL go to IDLE.
REQ-032 While HREADYOUT=0, SHALL ignore HTRANS, HADDR, HSIZE and HWRITE.
REQ-033 Outside RD_DONE: HRDATA=0. Outside WRITE: ram_we=0. In IDLE: ram_addr, ram_data and ram_size SHALL hold their last values.
REQ-034 Read immediately after write: the write commits in WRITE and the read port access starts the next cycle; no same-cycle port conflict.

Reset
REQ-035 While HRESETn=0: state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, ram_we=0, ram_addr=0, ram_data=0, ram_size=BYTE. Reset mid-transfer SHALL abort it with no RAM write.

Configuration
REQ-036 With macro AHB_RAM_ALIGN_CHECK_EN defined, a HALFWORD with HADDR[0]=1 or a WORD with HADDR[1:0]!=0 SHALL be illegal and take the ERR1/ERR2 path. Without the macro, such a transfer proceeds, and ram_addr carries the unmodified address.

Verification
REQ-037 Bench SHALL write WORD 0xDEADBEEF at 0x010, then read WORD at 0x010 -> write has zero wait states; read has one HREADYOUT=0 cycle, then HRDATA=0xDEADBEEF with HRESP=0.
REQ-038 Bench SHALL write BYTE 0x000000AA at 0x013 (lane 3, HWDATA=0xAA000000), then read BYTE at 0x013 -> HRDATA=0xAA000000.
REQ-039 Bench SHALL read at address ADDR_LIMIT -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; ram_we stays 0.
REQ-040 Bench SHALL issue HALFWORD at 0x021 -> with AHB_RAM_ALIGN_CHECK_EN: two-cycle ERROR; without it: OKAY access.
REQ-041 Bench SHALL issue back-to-back NONSEQ write, read, write -> write commits, read inserts 1 wait, last write is accepted only when HREADYOUT=1.
REQ-042 Bench SHALL assert HRESETn=0 during RD_WAIT -> next edge in IDLE; HREADYOUT=1, HRDATA=0, RAM unchanged.
